// File: rtl/seq_gen_pkg.sv
// Shared constants for the serial sequence generator and its shadow detector model.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the detector state encodings (state0..state3) and the generator
// control FSM encoding, shared by seq_gen, seq_shadow and detector benches.
package seq_gen_pkg;

    // Sequence detector state encodings
    localparam logic [1:0] STATE0 = 2'b00;
    localparam logic [1:0] STATE1 = 2'b01;
    localparam logic [1:0] STATE2 = 2'b10;
    localparam logic [1:0] STATE3 = 2'b11;

    // Generator control FSM
    typedef enum logic [1:0] {
        GEN_IDLE = 2'b00,
        GEN_SEND = 2'b01,
        GEN_DONE = 2'b10
    } gen_st_e;

endpackage

// File: rtl/seq_gen_shadow.sv
// Combinational next-state and Mealy Z model of the sequence detector.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller decides when next_st is committed.
//
// Ports:
//   pres_st : present detector state
//   a       : detector input bit
//   next_st : detector state after consuming a
//   z       : Mealy output, high when a=1 is seen in state0
module seq_shadow
    import seq_gen_pkg::*;
(
    input  logic [1:0] pres_st,
    input  logic       a,
    output logic [1:0] next_st,
    output logic       z
);

    always_comb begin
        next_st = STATE0;
        case (pres_st)
            STATE0:  next_st = a ? STATE1 : STATE0;
            STATE1:  next_st = a ? STATE2 : STATE3;
            STATE2:  next_st = a ? STATE3 : STATE0;
            STATE3:  next_st = a ? STATE0 : STATE1;
            default: next_st = STATE0;
        endcase
    end

    assign z = (pres_st == STATE0) && a;

endmodule

// File: rtl/seq_gen.sv
// Serial pattern generator (LSB first) with a shadow model of the downstream detector.
// Latency: first bit valid the cycle after an accepted start; done pulses the cycle after the last transfer.
// Backpressure: a bit moves only when a_valid && ready; with ready low all state holds.
//
// Ports:
//   clk, rst_n       : clock, asynchronous active-low reset
//   start            : load request, honoured only in IDLE with len != 0
//   pattern, len     : bits to send and bit count (len clamped to PAT_W)
//   ready            : downstream accept for the current bit
//   a_out, a_valid   : serial bit and its valid flag
//   busy, done       : run in progress / one-cycle completion pulse
//   pres_st, z_exp   : shadow detector state and expected Mealy Z
//   z_count          : saturating count of z_exp transfers in the current run
module seq_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = 16,
    parameter int LEN_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic             ready,
    output logic             a_out,
    output logic             a_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       pres_st,
    output logic             z_exp,
    output logic [LEN_W-1:0] z_count
);

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    gen_st_e          state_q,   state_d;
    logic [PAT_W-1:0] shift_q,   shift_d;
    logic [LEN_W-1:0] len_q,     len_d;
    logic [LEN_W-1:0] cnt_q,     cnt_d;
    logic [1:0]       pres_st_q, pres_st_d;
    logic [LEN_W-1:0] z_count_q, z_count_d;

    logic [LEN_W-1:0] len_clamped;
    logic [1:0]       shadow_next;
    logic             shadow_z;

    assign len_clamped = (len > LEN_MAX) ? LEN_MAX : len;

    seq_shadow u_shadow (
        .pres_st (pres_st_q),
        .a       (a_out),
        .next_st (shadow_next),
        .z       (shadow_z)
    );

    // Outputs are decoded from state so reset forces them immediately.
    assign a_valid = (state_q == GEN_SEND);
    assign a_out   = a_valid && shift_q[0];
    assign busy    = (state_q != GEN_IDLE);
    assign done    = (state_q == GEN_DONE);
    assign z_exp   = a_valid && shadow_z;
    assign pres_st = pres_st_q;
    assign z_count = z_count_q;

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        pres_st_d = pres_st_q;
        z_count_d = z_count_q;
        case (state_q)
            GEN_IDLE: begin
                if (start && (len != '0)) begin
                    shift_d   = pattern;
                    len_d     = len_clamped;
                    cnt_d     = '0;
                    z_count_d = '0;
                    pres_st_d = STATE0;
                    state_d   = GEN_SEND;
                end
            end
            GEN_SEND: begin
                if (ready) begin
                    shift_d   = {1'b0, shift_q[PAT_W-1:1]};
                    cnt_d     = cnt_q + LEN_W'(1);
                    pres_st_d = shadow_next;
                    if (z_exp && (z_count_q != '1)) begin
                        z_count_d = z_count_q + LEN_W'(1);
                    end
                    // len_q is never zero here, so len_q-1 is the last index.
                    if (cnt_q == (len_q - LEN_W'(1))) begin
                        state_d = GEN_DONE;
                    end
                end
            end
            GEN_DONE: begin
                state_d = GEN_IDLE;
            end
            default: begin
                state_d = GEN_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= GEN_IDLE;
            shift_q   <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            pres_st_q <= STATE0;
            z_count_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            pres_st_q <= pres_st_d;
            z_count_q <= z_count_d;
        end
    end

endmodule
